// File: rtl/cache_line_refill_ctrl.sv
// Miss-handling engine for one cache line: optional victim writeback burst,
// then a refill read burst written word-by-word into the line data storage.
module cache_line_refill_ctrl #(
  parameter int DATA_WIDTH     = 32,
  parameter int WORDS_PER_LINE = 16,
  parameter int NUM_SETS       = 128,
  parameter int ADDR_WIDTH     = 32,
  parameter int TAG_WIDTH      = ADDR_WIDTH - $clog2(NUM_SETS) - $clog2(WORDS_PER_LINE)
                                 - $clog2(DATA_WIDTH/8)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              req_valid,
  output logic                              req_ready,
  input  logic [$clog2(NUM_SETS)-1:0]       req_index,
  input  logic [TAG_WIDTH-1:0]              req_tag,
  input  logic                              req_dirty,
  input  logic [TAG_WIDTH-1:0]              req_victim_tag,
  output logic                              done,
  output logic                              da_we,
  output logic [$clog2(NUM_SETS)-1:0]       da_index,
  output logic [$clog2(WORDS_PER_LINE)-1:0] da_word_idx,
  output logic [DATA_WIDTH-1:0]             da_wdata,
  output logic [DATA_WIDTH/8-1:0]           da_wstrb,
  input  logic [DATA_WIDTH-1:0]             da_rdata,
  output logic                              mem_req_valid,
  input  logic                              mem_req_ready,
  output logic                              mem_req_we,
  output logic [ADDR_WIDTH-1:0]             mem_req_addr,
  output logic                              mem_wvalid,
  input  logic                              mem_wready,
  output logic [DATA_WIDTH-1:0]             mem_wdata,
  output logic                              mem_wlast,
  input  logic                              mem_rvalid,
  output logic                              mem_rready,
  input  logic [DATA_WIDTH-1:0]             mem_rdata
);

  localparam int IDX_W  = $clog2(NUM_SETS);
  localparam int WORD_W = $clog2(WORDS_PER_LINE);
  localparam int LOW_W  = WORD_W + $clog2(DATA_WIDTH/8);
  localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(WORDS_PER_LINE - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WB_REQ, S_WB_DATA, S_RD_REQ, S_RD_DATA, S_DONE
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [WORD_W-1:0]   r_cnt, w_cnt_nxt;
  logic [IDX_W-1:0]    r_index;
  logic [TAG_WIDTH-1:0] r_tag, r_victim_tag;
  logic                w_accept;
  logic                w_last;

  assign w_accept = req_valid && (r_state == S_IDLE);
  assign w_last   = (r_cnt == LAST_WORD);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_index      <= '0;
      r_tag        <= '0;
      r_victim_tag <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_index      <= req_index;
        r_tag        <= req_tag;
        r_victim_tag <= req_victim_tag;
      end
    end
  end

  // NOTE: every output and next-state variable gets a default before the case,
  // so no path through this block can infer a latch.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    req_ready     = 1'b0;
    done          = 1'b0;
    da_we         = 1'b0;
    da_index      = r_index;
    da_word_idx   = '0;
    da_wdata      = '0;
    da_wstrb      = '0;
    mem_req_valid = 1'b0;
    mem_req_we    = 1'b0;
    mem_req_addr  = '0;
    mem_wvalid    = 1'b0;
    mem_wdata     = '0;
    mem_wlast     = 1'b0;
    mem_rready    = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) w_state_nxt = req_dirty ? S_WB_REQ : S_RD_REQ;
      end
      S_WB_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_we    = 1'b1;
        mem_req_addr  = {r_victim_tag, r_index, {LOW_W{1'b0}}};
        if (mem_req_ready) begin
          w_state_nxt = S_WB_DATA;
          w_cnt_nxt   = '0;
        end
      end
      S_WB_DATA: begin
        // Storage read is combinational, so the beat data tracks the counter.
        da_word_idx = r_cnt;
        mem_wvalid  = 1'b1;
        mem_wdata   = da_rdata;
        mem_wlast   = w_last;
        if (mem_wready) begin
          w_cnt_nxt = r_cnt + 1'b1;
          if (w_last) w_state_nxt = S_RD_REQ;
        end
      end
      S_RD_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = {r_tag, r_index, {LOW_W{1'b0}}};
        if (mem_req_ready) begin
          w_state_nxt = S_RD_DATA;
          w_cnt_nxt   = '0;
        end
      end
      S_RD_DATA: begin
        mem_rready  = 1'b1;
        da_word_idx = r_cnt;
        if (mem_rvalid) begin
          da_we     = 1'b1;
          da_wstrb  = '1;
          da_wdata  = mem_rdata;
          w_cnt_nxt = r_cnt + 1'b1;
          if (w_last) w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_cache_line_refill_ctrl.sv
// Directed bench for cache_line_refill_ctrl: table of refill scenarios plus
// hand sequences for reset mid-refill, back-to-back and ignored requests.
module tb_cache_line_refill_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_dirty;
  logic [6:0]  req_index;
  logic [18:0] req_tag, req_victim_tag;
  logic        done, da_we;
  logic [6:0]  da_index;
  logic [3:0]  da_word_idx;
  logic [31:0] da_wdata, da_rdata;
  logic [3:0]  da_wstrb;
  logic        mem_req_valid, mem_req_ready, mem_req_we;
  logic [31:0] mem_req_addr;
  logic        mem_wvalid, mem_wready, mem_wlast;
  logic [31:0] mem_wdata;
  logic        mem_rvalid, mem_rready;
  logic [31:0] mem_rdata;

  logic [31:0] storage [128][16];
  int total = 0, bad = 0;
  int acc_cnt = 0, done_cnt = 0, we_viol = 0;

  always #5 clk = ~clk;

  cache_line_refill_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_index(req_index),
    .req_tag(req_tag), .req_dirty(req_dirty), .req_victim_tag(req_victim_tag),
    .done(done),
    .da_we(da_we), .da_index(da_index), .da_word_idx(da_word_idx),
    .da_wdata(da_wdata), .da_wstrb(da_wstrb), .da_rdata(da_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr),
    .mem_wvalid(mem_wvalid), .mem_wready(mem_wready), .mem_wdata(mem_wdata),
    .mem_wlast(mem_wlast),
    .mem_rvalid(mem_rvalid), .mem_rready(mem_rready), .mem_rdata(mem_rdata)
  );

  // Line data storage model: combinational read, byte-strobed write.
  assign da_rdata = storage[da_index][da_word_idx];

  always @(posedge clk) begin
    if (da_we)
      for (int b = 0; b < 4; b++)
        if (da_wstrb[b]) storage[da_index][da_word_idx][b*8 +: 8] = da_wdata[b*8 +: 8];
    if (req_valid && req_ready) acc_cnt++;
    if (done) done_cnt++;
    if (da_we && !(mem_rvalid && mem_rready)) we_viol++;
  end

  typedef struct {
    logic [6:0]  index;
    logic [18:0] tag;
    logic        dirty;
    logic [18:0] victim;
    logic [31:0] wb_addr;
    logic [31:0] rd_addr;
    logic [31:0] wb_base;
    logic [31:0] rd_base;
    int          stall;
    logic        wtog;
    int          rgap;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    check(name, {req_ready, done, da_we, da_index, da_word_idx, da_wdata, da_wstrb,
                 mem_req_valid, mem_req_we, mem_wvalid, mem_wlast, mem_rready},
          {1'b1, 54'd0});
    check({name, "_data"}, {mem_req_addr, mem_wdata}, 64'd0);
  endtask

  task automatic req_phase(input logic [31:0] addr, input logic we, input int stall);
    for (int s = 0; s <= stall; s++) begin
      check("mem_req", {mem_req_valid, mem_req_we, mem_req_addr, mem_wvalid, mem_rready, da_we},
            {1'b1, we, addr, 1'b0, 1'b0, 1'b0});
      mem_req_ready = (s == stall);
      @(posedge clk); #1;
    end
    mem_req_ready = 1'b0;
  endtask

  // Entered and left at #1 after a rising edge with the DUT in IDLE.
  task automatic run_refill(input vec_t v, input logic hold, input logic pulse, input int abort);
    int   beat;
    int   acc0;
    int   done0;
    logic rdy;
    acc0  = acc_cnt;
    done0 = done_cnt;
    if (v.dirty)
      for (int i = 0; i < 16; i++) storage[v.index][i] = v.wb_base + 32'(i);
    check("req_ready_idle", 64'(req_ready), 64'd1);
    req_valid = 1'b1; req_index = v.index; req_tag = v.tag;
    req_dirty = v.dirty; req_victim_tag = v.victim;
    @(posedge clk); #1;
    if (!hold) req_valid = 1'b0;

    if (v.dirty) begin
      req_phase(v.wb_addr, 1'b1, v.stall);
      beat = 0;
      for (int c = 0; c < 64 && beat < 16; c++) begin
        rdy = v.wtog ? (c % 2 == 0) : 1'b1;
        check("wb_beat", {mem_wvalid, mem_wlast, mem_wdata, da_we, mem_req_valid},
              {1'b1, beat == 15, v.wb_base + 32'(beat), 1'b0, 1'b0});
        mem_wready = rdy;
        if (rdy) beat++;
        @(posedge clk); #1;
      end
      mem_wready = 1'b0;
      check("wb_beat_count", 64'(beat), 64'd16);
    end

    req_phase(v.rd_addr, 1'b0, v.stall);
    for (int b = 0; b < 16; b++) begin
      for (int g = 0; g < v.rgap; g++) begin
        mem_rvalid = 1'b0;
        if (pulse) req_valid = 1'b0;
        #1;
        check("rd_gap", {mem_rready, da_we, req_ready}, {1'b1, 1'b0, 1'b0});
        @(posedge clk); #1;
      end
      if (pulse) begin
        req_valid = (b % 2 == 0);
        req_index = 7'd9;
      end
      mem_rvalid = 1'b1;
      mem_rdata  = v.rd_base + 32'(b);
      #1;
      check("rd_beat", {da_we, da_wstrb, da_index, da_word_idx, da_wdata,
                        mem_rready, mem_req_valid, req_ready, done},
            {1'b1, 4'hF, v.index, 4'(b), v.rd_base + 32'(b), 1'b1, 1'b0, 1'b0, 1'b0});
      @(posedge clk); #1;
      if (b == abort) begin
        mem_rvalid = 1'b0;
        return;
      end
    end
    mem_rvalid = 1'b0;
    req_valid  = hold;
    #1;
    check("done_pulse", {done, req_ready, da_we}, {1'b1, 1'b0, 1'b0});
    @(posedge clk); #1;
    check("done_clear", {done, req_ready}, {1'b0, 1'b1});
    check("accept_count", 64'(acc_cnt - acc0), 64'd1);
    check("done_count", 64'(done_cnt - done0), 64'd1);
    for (int i = 0; i < 16; i++)
      check("line_word", {32'(i), storage[v.index][i]}, {32'(i), v.rd_base + 32'(i)});
  endtask

  initial begin
    vec_t v;
    int   d0;

    vecs[0] = '{index: 7'd5, tag: 19'h1A2B3, dirty: 1'b0, victim: 19'h0,
                wb_addr: 32'h0, rd_addr: 32'h34566140, wb_base: 32'h0, rd_base: 32'h100,
                stall: 0, wtog: 1'b0, rgap: 0};
    vecs[1] = '{index: 7'd5, tag: 19'h1A2B3, dirty: 1'b1, victim: 19'h00001,
                wb_addr: 32'h00002140, rd_addr: 32'h34566140, wb_base: 32'hA0, rd_base: 32'h100,
                stall: 0, wtog: 1'b0, rgap: 0};
    vecs[2] = '{index: 7'd3, tag: 19'h7FFFF, dirty: 1'b1, victim: 19'h12345,
                wb_addr: 32'h2468A0C0, rd_addr: 32'hFFFFE0C0, wb_base: 32'h5000, rd_base: 32'h300,
                stall: 4, wtog: 1'b1, rgap: 3};
    vecs[3] = '{index: 7'd127, tag: 19'h0, dirty: 1'b0, victim: 19'h7FFFF,
                wb_addr: 32'h0, rd_addr: 32'h00001FC0, wb_base: 32'h0, rd_base: 32'hDEAD0000,
                stall: 1, wtog: 1'b0, rgap: 1};

    for (int s = 0; s < 128; s++)
      for (int w = 0; w < 16; w++) storage[s][w] = 32'h0;
    rst = 1'b1;
    req_valid = 1'b0; req_index = '0; req_tag = '0; req_dirty = 1'b0; req_victim_tag = '0;
    mem_req_ready = 1'b0; mem_wready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    #1;
    check_reset_outputs("reset_state");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 4; i++) run_refill(vecs[i], 1'b0, 1'b0, -1);

    // Reset asserted asynchronously after read beat 7, then a full refill.
    v = '{index: 7'd6, tag: 19'h1A2B3, dirty: 1'b0, victim: 19'h0,
          wb_addr: 32'h0, rd_addr: 32'h34566180, wb_base: 32'h0, rd_base: 32'h600,
          stall: 0, wtog: 1'b0, rgap: 0};
    d0 = done_cnt;
    run_refill(v, 1'b0, 1'b0, 7);
    #1 rst = 1'b1;
    #1;
    check_reset_outputs("reset_mid_refill");
    check("partial_word8", storage[6][8], 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    v.rd_base = 32'h400;
    run_refill(v, 1'b0, 1'b0, -1);
    check("no_spurious_done", 64'(done_cnt - d0), 64'd1);

    // req_valid held high across two requests.
    v = '{index: 7'd1, tag: 19'h1A2B3, dirty: 1'b0, victim: 19'h0,
          wb_addr: 32'h0, rd_addr: 32'h34566040, wb_base: 32'h0, rd_base: 32'h1000,
          stall: 0, wtog: 1'b0, rgap: 0};
    run_refill(v, 1'b1, 1'b0, -1);
    v.index = 7'd2; v.rd_addr = 32'h34566080; v.rd_base = 32'h2000;
    run_refill(v, 1'b0, 1'b0, -1);

    // req_valid pulses (index 9) during RD_DATA must be ignored.
    v = '{index: 7'd4, tag: 19'h00ABC, dirty: 1'b1, victim: 19'h3,
          wb_addr: 32'h00006100, rd_addr: 32'h01578100, wb_base: 32'hC0DE0000, rd_base: 32'h3000,
          stall: 1, wtog: 1'b1, rgap: 1};
    run_refill(v, 1'b0, 1'b1, -1);
    check("ignored_set9", storage[9][0], 32'h0);
    check("da_we_outside_beats", 64'(we_viol), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
